// File: rtl/interfaz_captura_vga.sv
// interfaz_captura_vga: once-per-frame BCD snapshot to ASCII plus VGA colour path.
// Captures NUM_CANALES packed-BCD bytes on entry to vertical blanking, converts
// each nibble to 7-bit ASCII, flags non-BCD nibbles, and drives the registered
// 12-bit RGB output through the palette, graphics mux and alarm band.
// Optional feature macro: PARPADEO_ALARMA_EN (blinking alarm band). When it is
// undefined the band is solid whenever ring is high and no blink counter exists.
module interfaz_captura_vga #(
  parameter int          NUM_CANALES     = 11,
  parameter int          ALTO_VISIBLE    = 480,
  parameter int          CICLOS_PARPADEO = 100000000,
  parameter int          ALARMA_Y_INI    = 473,
  parameter int          ALARMA_Y_FIN    = 480,
  parameter logic [11:0] COLOR_FONDO     = 12'h032
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [9:0]                pixely,
  input  logic                      video_on,
  input  logic                      dp,
  input  logic                      graficos,
  input  logic [11:0]               datoMemoria,
  input  logic [2:0]                color_addr,
  input  logic [8*NUM_CANALES-1:0]  datos_in,
  input  logic                      congelar,
  input  logic                      ring,
  output logic [14*NUM_CANALES-1:0] ascii_out,
  output logic                      captura_tick,
  output logic [NUM_CANALES-1:0]    bcd_error,
  output logic [11:0]               rgbO
);

  localparam logic [9:0]  ALTO_S      = 10'(ALTO_VISIBLE);
  localparam logic [9:0]  BANDA_INI_S = 10'(ALARMA_Y_INI);
  localparam logic [9:0]  BANDA_FIN_S = 10'(ALARMA_Y_FIN);
  localparam logic [11:0] COLOR_ALARMA = 12'hF00;

  // A nibble above 9 is not a decimal digit and renders as a dash.
  function automatic logic nibble_invalido(input logic [3:0] n);
    return (n > 4'd9);
  endfunction

  function automatic logic [6:0] bcd_a_ascii(input logic [3:0] n);
    logic [6:0] c;
    if (nibble_invalido(n)) begin
      c = 7'h2D;
    end else begin
      c = {3'b011, n};
    end
    return c;
  endfunction

  logic                      blk_s;
  logic                      blk_r;
  logic                      ev_s;
  logic [14*NUM_CANALES-1:0] ascii_s;
  logic [NUM_CANALES-1:0]    err_s;
  logic                      fase_s;
  logic                      banda_s;
  logic [11:0]               paleta_s;
  logic [11:0]               mux_s;

  assign blk_s = (pixely >= ALTO_S);
  // Rising edge of the blanking flag: one event per frame.
  assign ev_s  = blk_s & ~blk_r;

  // Conversion of every channel from the live input bytes.
  always_comb begin
    ascii_s = '0;
    err_s   = '0;
    for (int k = 0; k < NUM_CANALES; k++) begin
      ascii_s[14*k +: 7]   = bcd_a_ascii(datos_in[8*k +: 4]);
      ascii_s[14*k+7 +: 7] = bcd_a_ascii(datos_in[8*k+4 +: 4]);
      err_s[k] = nibble_invalido(datos_in[8*k +: 4]) |
                 nibble_invalido(datos_in[8*k+4 +: 4]);
    end
  end

  // Blanking edge tracking and once-per-frame capture of all channels.
  always_ff @(posedge clk) begin
    if (reset) begin
      blk_r        <= 1'b0;
      captura_tick <= 1'b0;
      ascii_out    <= {(2*NUM_CANALES){7'h30}};
      bcd_error    <= '0;
    end else begin
      blk_r <= blk_s;
      if (ev_s && !congelar) begin
        captura_tick <= 1'b1;
        ascii_out    <= ascii_s;
        bcd_error    <= err_s;
      end else begin
        captura_tick <= 1'b0;
      end
    end
  end

`ifdef PARPADEO_ALARMA_EN
  localparam int CW = (CICLOS_PARPADEO > 1) ? $clog2(CICLOS_PARPADEO) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(CICLOS_PARPADEO - 1);

  logic [CW-1:0] cnt_r;
  logic          fase_r;

  // Blink phase generator: runs only while the alarm rings, cleared otherwise.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_r  <= '0;
      fase_r <= 1'b0;
    end else if (!ring) begin
      cnt_r  <= '0;
      fase_r <= 1'b0;
    end else if (cnt_r == CNT_MAX) begin
      cnt_r  <= '0;
      fase_r <= ~fase_r;
    end else begin
      cnt_r  <= cnt_r + CW'(1);
    end
  end

  assign fase_s = fase_r;
`else
  assign fase_s = 1'b1;
`endif

  // Palette ROM indexed by the renderer colour index.
  always_comb begin
    paleta_s = COLOR_FONDO;
    case (color_addr)
      3'd0:    paleta_s = 12'h032;
      3'd1:    paleta_s = 12'h000;
      3'd2:    paleta_s = 12'hFFE;
      3'd3:    paleta_s = 12'h111;
      3'd4:    paleta_s = 12'h222;
      3'd5:    paleta_s = 12'h333;
      3'd6:    paleta_s = 12'h032;
      3'd7:    paleta_s = 12'h120;
      default: paleta_s = COLOR_FONDO;
    endcase
  end

  assign banda_s = ring && fase_s && (pixely >= BANDA_INI_S) && (pixely <= BANDA_FIN_S);

  // Colour priority: graphics memory, then alarm band, then palette.
  always_comb begin
    mux_s = paleta_s;
    if (graficos) begin
      mux_s = datoMemoria;
    end else if (banda_s) begin
      mux_s = COLOR_ALARMA;
    end else begin
      mux_s = paleta_s;
    end
  end

  // Registered pixel colour; background outside lit visible pixels.
  always_ff @(posedge clk) begin
    if (reset) begin
      rgbO <= COLOR_FONDO;
    end else if (video_on && dp) begin
      rgbO <= mux_s;
    end else begin
      rgbO <= COLOR_FONDO;
    end
  end

endmodule

// File: tb/tb_interfaz_captura_vga.sv
// Self-checking bench for interfaz_captura_vga (capture, ASCII, palette, alarm band).
// Honours PARPADEO_ALARMA_EN for the expected band pattern.
module tb_interfaz_captura_vga;

  localparam int N  = 11;
  localparam int CP = 4;

  logic              clk = 1'b0;
  logic              reset;
  logic [9:0]        pixely;
  logic              video_on, dp, graficos, congelar, ring;
  logic [11:0]       datoMemoria;
  logic [2:0]        color_addr;
  logic [8*N-1:0]    datos_in;
  logic [14*N-1:0]   ascii_out;
  logic              captura_tick;
  logic [N-1:0]      bcd_error;
  logic [11:0]       rgbO;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [14*N-1:0] a;
    logic [N-1:0]    e;
  } cap_t;

  cap_t        capq[$];
  logic [11:0] rgbq[$];
  cap_t        ultimo;

  logic [11:0] pal_ref [8] = '{12'h032, 12'h000, 12'hFFE, 12'h111,
                               12'h222, 12'h333, 12'h032, 12'h120};

  interfaz_captura_vga #(
    .NUM_CANALES(N), .ALTO_VISIBLE(480), .CICLOS_PARPADEO(CP),
    .ALARMA_Y_INI(473), .ALARMA_Y_FIN(480), .COLOR_FONDO(12'h032)
  ) dut (
    .clk(clk), .reset(reset), .pixely(pixely), .video_on(video_on), .dp(dp),
    .graficos(graficos), .datoMemoria(datoMemoria), .color_addr(color_addr),
    .datos_in(datos_in), .congelar(congelar), .ring(ring),
    .ascii_out(ascii_out), .captura_tick(captura_tick), .bcd_error(bcd_error),
    .rgbO(rgbO)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] ref_ascii(input logic [3:0] n);
    return (n > 4'd9) ? 7'h2D : (7'h30 + {3'b000, n});
  endfunction

  function automatic cap_t ref_captura(input logic [8*N-1:0] d);
    cap_t r;
    for (int k = 0; k < N; k++) begin
      r.a[14*k +: 7]   = ref_ascii(d[8*k +: 4]);
      r.a[14*k+7 +: 7] = ref_ascii(d[8*k+4 +: 4]);
      r.e[k]           = (d[8*k +: 4] > 4'd9) || (d[8*k+4 +: 4] > 4'd9);
    end
    return r;
  endfunction

  function automatic logic [8*N-1:0] datos_base(input int semilla);
    logic [8*N-1:0] d;
    for (int k = 0; k < N; k++) begin
      d[8*k+4 +: 4] = 4'((k + semilla) % 10);
      d[8*k +: 4]   = 4'((3*k + semilla + 1) % 10);
    end
    return d;
  endfunction

  task automatic ciclo();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    ciclo();
    ciclo();
    checks++;
    if (ascii_out !== {(2*N){7'h30}}) begin
      errors++; $display("FAIL reset_ascii got=%h exp=all 30", ascii_out);
    end
    checks++;
    if (captura_tick !== 1'b0) begin
      errors++; $display("FAIL reset_tick got=%b exp=0", captura_tick);
    end
    checks++;
    if (bcd_error !== '0) begin
      errors++; $display("FAIL reset_bcd_error got=%h exp=0", bcd_error);
    end
    checks++;
    if (rgbO !== 12'h032) begin
      errors++; $display("FAIL reset_rgb got=%h exp=032", rgbO);
    end
    reset = 1'b0;
    ciclo();
  endtask

  task automatic test_capture();
    cap_t exp;
    int   ticks;
    datos_in = datos_base(2);
    datos_in[7:0] = 8'h59;
    pixely = 10'd479;
    ciclo();
    checks++;
    if (captura_tick !== 1'b0) begin
      errors++; $display("FAIL cap_pre_tick got=%b exp=0", captura_tick);
    end
    pixely = 10'd480;
    capq.push_back(ref_captura(datos_in));
    ciclo();
    exp = capq.pop_front();
    ultimo = exp;
    checks++;
    if (captura_tick !== 1'b1) begin
      errors++; $display("FAIL cap_tick got=%b exp=1", captura_tick);
    end
    checks++;
    if (ascii_out[6:0] !== 7'h39 || ascii_out[13:7] !== 7'h35) begin
      errors++; $display("FAIL cap_ch0 got=%h/%h exp=39/35", ascii_out[6:0], ascii_out[13:7]);
    end
    checks++;
    if (ascii_out !== exp.a) begin
      errors++; $display("FAIL cap_ascii got=%h exp=%h", ascii_out, exp.a);
    end
    checks++;
    if (bcd_error !== exp.e) begin
      errors++; $display("FAIL cap_bcd_error got=%h exp=%h", bcd_error, exp.e);
    end
    ticks = 0;
    for (int i = 0; i < 40; i++) begin
      ciclo();
      if (captura_tick === 1'b1) ticks++;
    end
    checks++;
    if (ticks != 0) begin
      errors++; $display("FAIL cap_hold_ticks got=%0d exp=0", ticks);
    end
  endtask

  task automatic frame_capture(input logic [8*N-1:0] d, input string nombre);
    cap_t exp;
    pixely = 10'd100;
    ciclo();
    datos_in = d;
    pixely = 10'd480;
    capq.push_back(ref_captura(d));
    ciclo();
    exp = capq.pop_front();
    ultimo = exp;
    checks++;
    if (captura_tick !== 1'b1) begin
      errors++; $display("FAIL %s_tick got=%b exp=1", nombre, captura_tick);
    end
    checks++;
    if (ascii_out !== exp.a || bcd_error !== exp.e) begin
      errors++; $display("FAIL %s_data got=%h err=%h exp=%h err=%h",
                         nombre, ascii_out, bcd_error, exp.a, exp.e);
    end
  endtask

  task automatic test_non_bcd();
    logic [8*N-1:0] d;
    d = datos_base(5);
    d[23:16] = 8'h3C;
    frame_capture(d, "nbcd");
    checks++;
    if (ascii_out[34:28] !== 7'h2D || ascii_out[41:35] !== 7'h33 || bcd_error[2] !== 1'b1) begin
      errors++; $display("FAIL nbcd_ch2 got=%h/%h err=%b exp=2D/33 err=1",
                         ascii_out[34:28], ascii_out[41:35], bcd_error[2]);
    end
    d[23:16] = 8'h23;
    frame_capture(d, "nbcd_fix");
    checks++;
    if (ascii_out[34:28] !== 7'h33 || ascii_out[41:35] !== 7'h32 || bcd_error[2] !== 1'b0) begin
      errors++; $display("FAIL nbcd_fix_ch2 got=%h/%h err=%b exp=33/32 err=0",
                         ascii_out[34:28], ascii_out[41:35], bcd_error[2]);
    end
  endtask

  task automatic test_freeze();
    logic [8*N-1:0] d;
    int ticks;
    pixely = 10'd100;
    ciclo();
    congelar = 1'b1;
    datos_in = datos_base(7);
    pixely = 10'd480;
    ciclo();
    checks++;
    if (captura_tick !== 1'b0) begin
      errors++; $display("FAIL frz_tick got=%b exp=0", captura_tick);
    end
    checks++;
    if (ascii_out !== ultimo.a || bcd_error !== ultimo.e) begin
      errors++; $display("FAIL frz_hold got=%h exp=%h", ascii_out, ultimo.a);
    end
    congelar = 1'b0;
    ticks = 0;
    for (int i = 0; i < 5; i++) begin
      ciclo();
      if (captura_tick === 1'b1) ticks++;
    end
    checks++;
    if (ticks != 0) begin
      errors++; $display("FAIL frz_deferred got=%0d exp=0", ticks);
    end
    d = datos_base(7);
    d[15:8] = 8'hA7;
    frame_capture(d, "frz_next");
  endtask

  task automatic test_blink();
    logic [11:0] exp;
    logic        fase;
    pixely = 10'd475; graficos = 1'b0; video_on = 1'b1; dp = 1'b1;
    color_addr = 3'd2; ring = 1'b0;
    ciclo();
    ring = 1'b1;
    for (int k = 0; k < 16; k++) begin
`ifdef PARPADEO_ALARMA_EN
      fase = ((k / CP) % 2) == 1;
`else
      fase = 1'b1;
`endif
      rgbq.push_back(fase ? 12'hF00 : 12'hFFE);
      ciclo();
      exp = rgbq.pop_front();
      checks++;
      if (rgbO !== exp) begin
        errors++; $display("FAIL blink_%0d got=%h exp=%h", k, rgbO, exp);
      end
    end
    pixely = 10'd470;
    for (int k = 0; k < 8; k++) begin
      rgbq.push_back(12'hFFE);
      ciclo();
      exp = rgbq.pop_front();
      checks++;
      if (rgbO !== exp) begin
        errors++; $display("FAIL blink_outside_%0d got=%h exp=%h", k, rgbO, exp);
      end
    end
    pixely = 10'd475;
    ring = 1'b0;
    for (int k = 0; k < 4; k++) begin
      rgbq.push_back(12'hFFE);
      ciclo();
      exp = rgbq.pop_front();
      checks++;
      if (rgbO !== exp) begin
        errors++; $display("FAIL blink_ringoff_%0d got=%h exp=%h", k, rgbO, exp);
      end
    end
  endtask

  task automatic test_priority();
    logic [11:0] exp;
    ring = 1'b1; pixely = 10'd475; graficos = 1'b1; datoMemoria = 12'hABC;
    video_on = 1'b1; dp = 1'b1;
    for (int k = 0; k < 10; k++) begin
      rgbq.push_back(12'hABC);
      ciclo();
      exp = rgbq.pop_front();
      checks++;
      if (rgbO !== exp) begin
        errors++; $display("FAIL prio_gfx_%0d got=%h exp=%h", k, rgbO, exp);
      end
    end
    dp = 1'b0;
    rgbq.push_back(12'h032);
    ciclo();
    exp = rgbq.pop_front();
    checks++;
    if (rgbO !== exp) begin
      errors++; $display("FAIL prio_dp0 got=%h exp=%h", rgbO, exp);
    end
    dp = 1'b1; video_on = 1'b0;
    rgbq.push_back(12'h032);
    ciclo();
    exp = rgbq.pop_front();
    checks++;
    if (rgbO !== exp) begin
      errors++; $display("FAIL prio_video0 got=%h exp=%h", rgbO, exp);
    end
    ring = 1'b0; graficos = 1'b0; video_on = 1'b1;
    for (int c = 0; c < 8; c++) begin
      color_addr = 3'(c);
      rgbq.push_back(pal_ref[c]);
      ciclo();
      exp = rgbq.pop_front();
      checks++;
      if (rgbO !== exp) begin
        errors++; $display("FAIL palette_%0d got=%h exp=%h", c, rgbO, exp);
      end
    end
  endtask

  task automatic test_reset_capture();
    cap_t exp;
    pixely = 10'd100; color_addr = 3'd2; dp = 1'b1; video_on = 1'b1;
    graficos = 1'b0; ring = 1'b0;
    ciclo();
    datos_in = datos_base(3);
    pixely = 10'd480;
    reset = 1'b1;
    ciclo();
    checks++;
    if (captura_tick !== 1'b0 || ascii_out !== {(2*N){7'h30}}) begin
      errors++; $display("FAIL rstcap_state got tick=%b ascii=%h exp tick=0 all 30",
                         captura_tick, ascii_out);
    end
    checks++;
    if (rgbO !== 12'h032 || bcd_error !== '0) begin
      errors++; $display("FAIL rstcap_rgb_err got=%h/%h exp=032/0", rgbO, bcd_error);
    end
    reset = 1'b0;
    datos_in = datos_base(8);
    capq.push_back(ref_captura(datos_in));
    ciclo();
    exp = capq.pop_front();
    checks++;
    if (captura_tick !== 1'b1) begin
      errors++; $display("FAIL rstcap_after_tick got=%b exp=1", captura_tick);
    end
    checks++;
    if (ascii_out !== exp.a || bcd_error !== exp.e) begin
      errors++; $display("FAIL rstcap_after_data got=%h exp=%h", ascii_out, exp.a);
    end
  endtask

  initial begin
    reset = 1'b1; pixely = 10'd0; video_on = 1'b0; dp = 1'b0; graficos = 1'b0;
    datoMemoria = 12'h000; color_addr = 3'd0; datos_in = '0; congelar = 1'b0;
    ring = 1'b0;
    test_reset();
    test_capture();
    test_non_bcd();
    test_freeze();
    test_blink();
    test_priority();
    test_reset_capture();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
